// File: rtl/odu_pkg.sv
// Shared constants and the field-strip helper for the ODU->OSU payload extractor.
// strip_field works on a MAX_W-wide word so any DATA_W up to MAX_W can use it.
package odu_pkg;

  localparam int DEF_DATA_W  = 384;
  localparam int DEF_STUFF_W = 128;
  localparam int DEF_HDR_W   = 56;
  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CH_W    = 4;
  localparam int DEF_CNT_W   = 16;

  localparam logic [7:0] STUFF_BYTE = 8'h99;

  localparam int MAX_W = 1024;
  localparam int MAX_B = MAX_W / 8;

  // word sits in the LSBs so a size cast of the result yields the word directly
  typedef struct packed {
    logic [MAX_B-1:0] mask;
    logic [MAX_W-1:0] word;
  } strip_t;

  // Opens a zero gap of 'width' bits at bit 'pos': bits below pos stay put, bits
  // above move up by 'width' and the top 'width' bits of the word fall off.
  function automatic strip_t strip_field(input logic [MAX_W-1:0] word,
                                         input logic [MAX_B-1:0] mask,
                                         input int pos,
                                         input int width);
    strip_t r;
    r.word = ((word >> pos) << (pos + width)) | (word & ~({MAX_W{1'b1}} << pos));
    r.mask = ((mask >> (pos / 8)) << ((pos + width) / 8)) |
             (mask & ~({MAX_B{1'b1}} << (pos / 8)));
    return r;
  endfunction

endpackage

// File: rtl/odu_pe_stats.sv
// Per-channel stuff-event counters: saturating increment, clear, registered read.
module odu_pe_stats
  import odu_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [CH_W-1:0]  inc_ch,
  input  logic [CH_W-1:0]  sel,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] rd_val;

  // Out-of-range selects match no channel, so they read 0 and clear nothing.
  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel == CH_W'(c)) rd_val = cnt_q[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= '0;
      cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr && sel == CH_W'(c)) begin
          cnt_q[c] <= (inc && inc_ch == CH_W'(c)) ? CNT_W'(1) : '0;
        end else if (inc && inc_ch == CH_W'(c) && cnt_q[c] != {CNT_W{1'b1}}) begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end
      end
      cnt <= rd_val;
    end
  end

endmodule

// File: rtl/odu_payload_extract.sv
// Two-stage ODU->OSU payload extractor: S1 strips stuff and RS gap, S2 the null header.
// Define ODU_PE_STATS_EN to build the per-channel stuff counters (o_cnt otherwise 0).
module odu_payload_extract
  import odu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int STUFF_W = DEF_STUFF_W,
  parameter int HDR_W   = DEF_HDR_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CH_W    = DEF_CH_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [CH_W-1:0]     i_chid,
  input  logic                i_rs,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DATA_W-1:0]   o_payload,
  output logic [DATA_W/8-1:0] o_byte_en,
  output logic [CH_W-1:0]     o_chid,
  output logic                o_err,
  input  logic [CH_W-1:0]     i_cnt_sel,
  input  logic                i_cnt_clr,
  output logic [CNT_W-1:0]    o_cnt
);

  localparam int BYTES   = DATA_W / 8;
  localparam int STUFF_B = STUFF_W / 8;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

  logic              chid_bad, stuff_hit, accept;
  logic [DATA_W-1:0] stuff_w, s1_word_d, s2_word_d;
  logic [BYTES-1:0]  stuff_m, s1_mask_d, s2_mask_d;

  logic              s1_valid, s1_err;
  logic [DATA_W-1:0] s1_word;
  logic [BYTES-1:0]  s1_mask;
  logic [CH_W-1:0]   s1_chid;

  logic              s2_valid, s2_err;
  logic [DATA_W-1:0] s2_word;
  logic [BYTES-1:0]  s2_mask;
  logic [CH_W-1:0]   s2_chid;

  // Handshake: a word moves on a rising edge where valid & ready are both high.
  // Both stages advance together whenever S2 is empty or downstream takes its word;
  // otherwise everything holds, so the output is stable under backpressure.
  assign o_ready = !s2_valid || i_ready;
  assign accept  = i_valid && o_ready;

  assign chid_bad  = {1'b0, i_chid} >= NUM_CH_L;
  assign stuff_hit = i_data[STUFF_W-1:0] == {STUFF_B{STUFF_BYTE}};

  always_comb begin
    stuff_w = i_data;
    stuff_m = '1;
    if (stuff_hit) begin
      stuff_w[STUFF_W-1:0] = {{(STUFF_W - 8){1'b0}}, i_data[STUFF_W +: 8]};
      stuff_m[STUFF_B-1:1] = '0;
    end
    s1_word_d = stuff_w;
    s1_mask_d = stuff_m;
    if (i_rs) begin
      s1_word_d = DATA_W'(strip_field(MAX_W'(stuff_w), MAX_B'(stuff_m), 8, STUFF_W));
      s1_mask_d = BYTES'(strip_field(MAX_W'(stuff_w), MAX_B'(stuff_m), 8, STUFF_W) >> MAX_W);
    end
    if (chid_bad) begin
      s1_word_d = i_data;
      s1_mask_d = '1;
    end
  end

  always_comb begin
    s2_word_d = s1_word;
    s2_mask_d = s1_mask;
    if (!s1_err && s1_word[DATA_W-1 -: HDR_W] == '0) begin
      s2_word_d = DATA_W'(strip_field(MAX_W'(s1_word), MAX_B'(s1_mask), 8, HDR_W));
      s2_mask_d = BYTES'(strip_field(MAX_W'(s1_word), MAX_B'(s1_mask), 8, HDR_W) >> MAX_W);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_mask  <= '0;
      s1_chid  <= '0;
      s1_err   <= 1'b0;
      s2_valid <= 1'b0;
      s2_word  <= '0;
      s2_mask  <= '0;
      s2_chid  <= '0;
      s2_err   <= 1'b0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      s1_word  <= s1_word_d;
      s1_mask  <= s1_mask_d;
      s1_chid  <= i_chid;
      s1_err   <= chid_bad;
      s2_valid <= s1_valid;
      s2_word  <= s2_word_d;
      s2_mask  <= s2_mask_d;
      s2_chid  <= s1_chid;
      s2_err   <= s1_err;
    end
  end

  assign o_valid   = s2_valid;
  assign o_payload = s2_word;
  assign o_byte_en = s2_mask;
  assign o_chid    = s2_chid;
  assign o_err     = s2_err;

`ifdef ODU_PE_STATS_EN
  odu_pe_stats #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .CNT_W  (CNT_W)
  ) u_stats (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .inc    (accept && stuff_hit && !chid_bad),
    .inc_ch (i_chid),
    .sel    (i_cnt_sel),
    .clr    (i_cnt_clr),
    .cnt    (o_cnt)
  );
`else
  logic stats_unused;
  assign stats_unused = ^{i_cnt_sel, i_cnt_clr, accept};
  assign o_cnt = '0;
`endif

endmodule

// File: tb/tb_odu_payload_extract.sv
// Directed bench for odu_payload_extract: golden model feeding an expected queue,
// negedge monitor popping it, counter model checked through o_cnt.
module tb_odu_payload_extract;

  localparam int DW    = 384;
  localparam int SW    = 128;
  localparam int HW    = 56;
  localparam int NCH   = 12;
  localparam int CW    = 4;
  localparam int NW    = 16;
  localparam int BW    = DW / 8;
  localparam int EXP_W = DW + BW + CW + 1;
`ifdef ODU_PE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          clk, rst_n;
  logic          i_valid, o_ready, i_rs, o_valid, i_ready, o_err, i_cnt_clr;
  logic [DW-1:0] i_data, o_payload;
  logic [BW-1:0] o_byte_en;
  logic [CW-1:0] i_chid, o_chid, i_cnt_sel;
  logic [NW-1:0] o_cnt;

  int num_checks = 0;
  int num_errors = 0;
  int n_in = 0;
  int n_out = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  int cnt_model [NCH];
  logic rdy_rand = 1'b0;
  logic rdy_val  = 1'b1;
  logic rnd_bit  = 1'b1;
  logic [DW-1:0] d;
  logic [SW-1:0] stuff_pat;

  assign i_ready = rdy_rand ? rnd_bit : rdy_val;

  odu_payload_extract #(
    .DATA_W (DW), .STUFF_W (SW), .HDR_W (HW),
    .NUM_CH (NCH), .CH_W (CW), .CNT_W (NW)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_chid    (i_chid),
    .i_rs      (i_rs),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_payload (o_payload),
    .o_byte_en (o_byte_en),
    .o_chid    (o_chid),
    .o_err     (o_err),
    .i_cnt_sel (i_cnt_sel),
    .i_cnt_clr (i_cnt_clr),
    .o_cnt     (o_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // ---------------- golden model ----------------
  function automatic logic [EXP_W-1:0] model(input logic [DW-1:0] din, input logic [CW-1:0] ch,
                                             input logic rs);
    logic [DW-1:0] w;
    logic [BW-1:0] m;
    if (ch >= NCH) return {din, {BW{1'b1}}, ch, 1'b1};
    w = din;
    m = '1;
    if (w[127:0] == {16{8'h99}}) begin
      w[127:0] = {120'h0, din[135:128]};
      m[15:1]  = '0;
    end
    if (rs) begin
      w = {w[255:8], 128'h0, w[7:0]};
      m = {m[31:1], 16'h0, m[0]};
    end
    if (w[383:328] == 56'h0) begin
      w = {w[327:8], 56'h0, w[7:0]};
      m = {m[40:1], 7'h0, m[0]};
    end
    return {w, m, ch, 1'b0};
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    w[15:8]   = 8'h00;
    w[DW-1]   = 1'b1;
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [EXP_W-1:0] obs, input logic [EXP_W-1:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_rule", EXP_W'(o_ready), EXP_W'(!o_valid || i_ready));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", EXP_W'(o_valid), '0);
        end else begin
          mon_e = exp_q.pop_front();
          check("payload", EXP_W'(o_payload), EXP_W'(mon_e[EXP_W-1 -: DW]));
          check("byte_en", EXP_W'(o_byte_en), EXP_W'(mon_e[CW+1 +: BW]));
          check("chid", EXP_W'(o_chid), EXP_W'(mon_e[1 +: CW]));
          check("err", EXP_W'(o_err), EXP_W'(mon_e[0]));
          n_out++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] din, input logic [CW-1:0] ch, input logic rs,
                      input logic clr, input logic [CW-1:0] sel);
    int n = 0;
    i_data = din; i_chid = ch; i_rs = rs; i_valid = 1'b1;
    i_cnt_clr = clr; i_cnt_sel = sel;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!o_ready) begin
      check("accept_timeout", EXP_W'(o_ready), EXP_W'(1'b1));
    end else begin
      exp_q.push_back(model(din, ch, rs));
      if (clr && sel < NCH) cnt_model[sel] = 0;
      if (ch < NCH && din[SW-1:0] == stuff_pat && cnt_model[ch] < 65535) cnt_model[ch]++;
      n_in++;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_cnt_clr = 1'b0;
  endtask

  task automatic chk_cnt(input logic [CW-1:0] sel, input string tag);
    int e;
    i_cnt_sel = sel;
    @(posedge clk);
    @(negedge clk);
    if (STATS_EN && sel < NCH) e = cnt_model[sel];
    else e = 0;
    check(tag, EXP_W'(o_cnt), EXP_W'(e));
    @(posedge clk); #1;
  endtask

  task automatic clr_cnt(input logic [CW-1:0] sel);
    i_cnt_sel = sel;
    i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    i_cnt_clr = 1'b0;
    if (sel < NCH) cnt_model[sel] = 0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check(tag, EXP_W'(exp_q.size()), '0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    check({pfx, "_o_valid"}, EXP_W'(o_valid), '0);
    check({pfx, "_o_payload"}, EXP_W'(o_payload), '0);
    check({pfx, "_o_byte_en"}, EXP_W'(o_byte_en), '0);
    check({pfx, "_o_chid"}, EXP_W'(o_chid), '0);
    check({pfx, "_o_err"}, EXP_W'(o_err), '0);
    check({pfx, "_o_cnt"}, EXP_W'(o_cnt), '0);
    check({pfx, "_o_ready"}, EXP_W'(o_ready), EXP_W'(1'b1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    stuff_pat = {16{8'h99}};
    foreach (cnt_model[c]) cnt_model[c] = 0;
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_chid = '0; i_rs = 1'b0;
    i_cnt_sel = '0; i_cnt_clr = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // stuff word on ch2
    d = rnd_word(); d[127:0] = stuff_pat; d[135:128] = 8'hA5;
    send(d, 4'd2, 1'b0, 1'b0, 4'd0);
    // RS word on ch1
    d = rnd_word();
    send(d, 4'd1, 1'b1, 1'b0, 4'd0);
    // null header on ch0
    d = rnd_word(); d[383:328] = '0;
    send(d, 4'd0, 1'b0, 1'b0, 4'd0);
    // all three strips on ch4: header becomes zero once the RS gap shifts d[255:200] up
    d = rnd_word(); d[127:0] = stuff_pat; d[255:200] = '0;
    send(d, 4'd4, 1'b1, 1'b0, 4'd0);
    // error channel: passes unmodified and is not counted
    d = rnd_word(); d[127:0] = stuff_pat; d[383:328] = '0;
    send(d, 4'(NCH), 1'b1, 1'b0, 4'd0);
    wait_drain("drain_directed");

    chk_cnt(4'd2, "cnt_ch2");
    chk_cnt(4'd4, "cnt_ch4");
    chk_cnt(4'd1, "cnt_ch1");
    chk_cnt(4'(NCH), "cnt_sel_oob");
    clr_cnt(4'(NCH));
    chk_cnt(4'd2, "cnt_after_oob_clr");
    d = rnd_word(); d[127:0] = stuff_pat;
    send(d, 4'd2, 1'b0, 1'b1, 4'd2);
    chk_cnt(4'd2, "cnt_clr_and_hit");
    clr_cnt(4'd4);
    chk_cnt(4'd4, "cnt_clr");
    wait_drain("drain_counters");

    // random backpressure, back-to-back words
    n_in = 0; n_out = 0;
    rdy_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int r;
      d = rnd_word();
      r = $urandom_range(0, 3);
      if (r == 1) d[127:0] = stuff_pat;
      if (r == 2) d[383:328] = '0;
      if (r == 3) begin d[127:0] = stuff_pat; d[255:200] = '0; end
      send(d, 4'($urandom_range(0, NCH)), 1'($urandom_range(0, 1)), 1'b0, 4'd0);
    end
    wait_drain("drain_backpressure");
    rdy_rand = 1'b0;
    check("no_loss", EXP_W'(n_out), EXP_W'(n_in));

    // saturation on ch5
    d = rnd_word(); d[127:0] = stuff_pat;
    for (int i = 0; i < 65535; i++) send(d, 4'd5, 1'b0, 1'b0, 4'd0);
    chk_cnt(4'd5, "cnt_sat_max");
    send(d, 4'd5, 1'b0, 1'b0, 4'd0);
    chk_cnt(4'd5, "cnt_sat_hold");
    wait_drain("drain_sat");

    // reset while stalled
    rdy_val = 1'b0;
    send(rnd_word(), 4'd6, 1'b0, 1'b0, 4'd0);
    send(rnd_word(), 4'd7, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    check("stall_o_ready", EXP_W'(o_ready), '0);
    check("stall_o_valid", EXP_W'(o_valid), EXP_W'(1'b1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    foreach (cnt_model[c]) cnt_model[c] = 0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    rdy_val = 1'b1;

    // first word after reset: presented in cycle 0, valid at output in cycle 2
    @(posedge clk); #1;
    d = rnd_word(); d[127:0] = stuff_pat;
    i_data = d; i_chid = 4'd3; i_rs = 1'b0; i_valid = 1'b1;
    exp_q.push_back(model(d, 4'd3, 1'b0));
    cnt_model[3]++;
    @(negedge clk);
    check("lat_cycle0", EXP_W'(o_valid), '0);
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", EXP_W'(o_valid), '0);
    @(negedge clk);
    check("lat_cycle2", EXP_W'(o_valid), EXP_W'(1'b1));
    @(posedge clk); #1;
    chk_cnt(4'd5, "cnt_ch5_after_reset");
    chk_cnt(4'd3, "cnt_ch3_after_reset");
    wait_drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
